// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into visible LED blinks. Events that arrive
// mid-blink are held in a saturating queue and played back to back.
module event_blinker #(
    parameter int TICK_DIV  = 250000,
    parameter int ON_TICKS  = 40,
    parameter int OFF_TICKS = 40,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_pulse,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             pend_nz;
    logic             full;
    logic             start;

    assign tick    = (pre_cnt == PRE_LAST);
    assign pend_nz = (pending != '0);
    assign full    = &pending;
    assign busy    = (state != IDLE) || pend_nz;

    // A blink starts on a tick from IDLE, or on the last OFF tick so queued
    // events play with no idle gap; it always looks at the registered count.
    assign start = tick && pend_nz &&
                   ((state == IDLE) || ((state == OFF) && (phase == OFF_LAST)));

    // NOTE: non-blocking assignments in every clocked block so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            led   <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ON;
                        phase <= '0;
                        led   <= 1'b1;
                    end
                end
                ON: begin
                    if (phase == ON_LAST) begin
                        state <= OFF;
                        phase <= '0;
                        led   <= 1'b0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                OFF: begin
                    if (phase == OFF_LAST) begin
                        phase <= '0;
                        if (start) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                    led   <= 1'b0;
                end
            endcase
        end
    end

    // An event coinciding with a start is a net zero, so it is accepted even
    // when the queue is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (event_pulse && !start) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + CNT_W'(1);
                end
            end else if (start && !event_pulse) begin
                pending <= pending - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: a timeline model of blinks and queue depth checked
// every cycle, plus literal expectations at hand-derived cycles.
module tb_event_blinker;

    localparam int D     = 4;
    localparam int ON_T  = 2;
    localparam int OFF_T = 1;
    localparam int CW    = 2;
    localparam int TOT   = (ON_T + OFF_T) * D;
    localparam int PMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          event_pulse = 1'b0;
    logic          led;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cur   = 0;

    event_blinker #(
        .TICK_DIV (D),
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .event_pulse(event_pulse),
        .led        (led),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s @t=%0t cycle=%0d: got %0d, want %0d", name, $time, cur, actual, expected);
        end
    endtask

    // Model: a blink that starts on the tick of cycle s lights the LED for
    // cycles s+1..s+ON*D and keeps the block busy through s+TOT; the next
    // start may happen on cycle s+TOT at the earliest.
    initial begin : model
        bit m_valid = 0;
        bit m_have  = 0;
        bit m_ovf   = 0;
        int m_c     = 0;
        int m_s     = 0;
        int m_pend  = 0;
        bit m_tick, m_free, m_start;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_led", int'(led),
                      int'(m_have && (m_c > m_s) && (m_c <= m_s + ON_T * D)));
                check("model_busy", int'(busy),
                      int'((m_have && (m_c <= m_s + TOT)) || (m_pend != 0)));
                check("model_pending", int'(pending), m_pend);
                check("model_overflow", int'(overflow), int'(m_ovf));
            end
            if (rst) begin
                m_valid = 1;
                m_c     = 0;
                m_pend  = 0;
                m_ovf   = 0;
                m_have  = 0;
            end else if (m_valid) begin
                m_tick  = ((m_c % D) == D - 1);
                m_free  = !m_have || (m_c >= m_s + TOT);
                m_start = m_tick && m_free && (m_pend != 0);
                m_ovf   = 0;
                if (event_pulse && !m_start) begin
                    if (m_pend == PMAX) m_ovf = 1;
                    else m_pend++;
                end else if (m_start && !event_pulse) begin
                    m_pend--;
                end
                if (m_start) begin
                    m_have = 1;
                    m_s    = m_c;
                end
                m_c++;
            end
        end
    end

    task automatic step(input logic ev);
        event_pulse = ev;
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic idle_to(input int k);
        while (cur < k) step(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        event_pulse = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 0;
    endtask

    initial begin
        // Single event at cycle 1.
        do_reset();
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pending", int'(pending), 0);
        step(1'b0);
        step(1'b1);
        check("single_pend_c2", int'(pending), 1);
        step(1'b0);
        check("single_pend_c3", int'(pending), 1);
        check("single_led_c3", int'(led), 0);
        step(1'b0);
        check("single_pend_c4", int'(pending), 0);
        check("single_led_c4", int'(led), 1);
        idle_to(11);
        check("single_led_c11", int'(led), 1);
        step(1'b0);
        check("single_led_c12", int'(led), 0);
        idle_to(15);
        check("single_busy_c15", int'(busy), 1);
        step(1'b0);
        check("single_busy_c16", int'(busy), 0);

        // Three events back to back, no idle gap between blinks.
        do_reset();
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("b2b_led_c4", int'(led), 1);
        check("b2b_pend_c4", int'(pending), 2);
        idle_to(15);
        check("b2b_led_c15", int'(led), 0);
        step(1'b0);
        check("b2b_led_c16", int'(led), 1);
        check("b2b_pend_c16", int'(pending), 1);
        idle_to(28);
        check("b2b_led_c28", int'(led), 1);
        check("b2b_pend_c28", int'(pending), 0);
        idle_to(39);
        check("b2b_busy_c39", int'(busy), 1);
        step(1'b0);
        check("b2b_busy_c40", int'(busy), 0);

        // Saturation, dropped event, and a full-queue event on the last OFF tick.
        do_reset();
        repeat (4) step(1'b1);
        check("sat_pend_c4", int'(pending), 3);
        check("sat_ovf_c4", int'(overflow), 0);
        check("sat_led_c4", int'(led), 1);
        step(1'b0);
        step(1'b1);
        check("sat_ovf_c6", int'(overflow), 1);
        check("sat_pend_c6", int'(pending), 3);
        step(1'b0);
        check("sat_ovf_c7", int'(overflow), 0);
        idle_to(15);
        step(1'b1);
        check("offtick_led_c16", int'(led), 1);
        check("offtick_pend_c16", int'(pending), 3);
        check("offtick_ovf_c16", int'(overflow), 0);
        idle_to(70);

        // Reset mid-blink drops the queue; the next blink is a full one.
        do_reset();
        step(1'b0);
        step(1'b1);
        step(1'b1);
        idle_to(6);
        check("rstmid_led_c6", int'(led), 1);
        check("rstmid_pend_c6", int'(pending), 1);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        cur = 0;
        check("rstmid_led_after", int'(led), 0);
        check("rstmid_pend_after", int'(pending), 0);
        check("rstmid_busy_after", int'(busy), 0);
        step(1'b0);
        step(1'b1);
        idle_to(4);
        check("rstmid_led_c4", int'(led), 1);
        idle_to(11);
        check("rstmid_led_c11", int'(led), 1);
        step(1'b0);
        check("rstmid_led_c12", int'(led), 0);
        idle_to(20);

        // Mixed directed pattern with a burst, checked by the model only.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(((i % 7) == 0) || ((i % 11) == 3) || ((i >= 40) && (i < 48)));
        end
        idle_to(420);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
